cpu_checkpoint_monitor: RTL
===========================

# cpu_checkpoint_monitor

Synthesizable checkpoint scoreboard that watches the CPU's retired-instruction count and `WWD` output port and checks them against a loadable table of (instruction count, expected value) pairs. It keeps per-entry pass/fail status, pass and fail counters, and the first failure. It ends the run on halt, on a cycle budget, on the first failure (optional), or once every entry has been checked. It sits beside `cpu` in the top level / bench and replaces open-coded checking loops with one reusable, parametrised block.

## Interface
- `WORD_SIZE`, 16, width of `num_inst`, `output_port` and expected values
- `NUM_TEST`, 56, number of table entries (1..64)
- `IDX_W`, 6, index width, ≥ clog2(`NUM_TEST`)
- `CYCLE_W`, 16, cycle counter width
- `MAX_CYCLES`, 10000, cycle budget per run (≥1, < 2^`CYCLE_W`)
- `STOP_ON_FAIL`, 1, 1 = end the run on the first mismatch; 0 = keep running

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `tbl_we`  in  1  table write strobe (honoured only in IDLE)
- `tbl_idx`  in  `IDX_W`  entry to write; indices ≥ `NUM_TEST` are ignored
- `tbl_num_inst`  in  `WORD_SIZE`  checkpoint instruction count
- `tbl_ans`  in  `WORD_SIZE`  expected `output_port` value
- `start`  in  1  begin run (honoured only in IDLE)
- `num_inst`  in  `WORD_SIZE`  CPU retired-instruction count
- `output_port`  in  `WORD_SIZE`  CPU WWD output
- `is_halted`  in  1  CPU halted
- `stat_idx`  in  `IDX_W`  status query index
- `stat`  out  2  status of `stat_idx`, combinational: 0 = unloaded, 1 = pending, 2 = pass, 3 = fail; 0 if index out of range
- `running`  out  1  state == RUN
- `done`  out  1  state == DONE
- `done_cause`  out  2  0 = all checked, 1 = halt, 2 = timeout, 3 = fail-stop
- `pass_cnt`  out  `IDX_W+1`  entries passed
- `fail_cnt`  out  `IDX_W+1`  entries failed
- `first_fail_valid`  out  1  at least one failure recorded
- `first_fail_idx`  out  `IDX_W`  index of first failure
- `first_fail_got`  out  `WORD_SIZE`  `output_port` value at that failure
- `cycle_cnt`  out  `CYCLE_W`  RUN cycles elapsed
- `all_pass`  out  1  `done` & `fail_cnt`==0 & `pass_cnt`==number of loaded entries

## Operation
- States: IDLE → RUN on `start`; RUN → DONE on a termination event; DONE → IDLE on `start`. The same `start` edge clears all statuses to pending, preserves table contents, and enters RUN.
- IDLE: `tbl_we` writes the entry and sets its status to pending (1). Rewriting an entry is allowed. `start` with zero loaded entries still enters RUN.
- RUN, every edge: each pending entry with `tbl_num_inst == num_inst` is checked.
  - `output_port == tbl_ans` → pass; otherwise → fail.
  - Status is sticky. Each entry is checked exactly once, on the first matching cycle.
  - Several entries may match on the same edge (duplicate counts). All of them are checked, and the counters add the number of passes and fails from that edge.
  - `first_fail_*` captures the lowest failing index on the first edge with any failure. Later failures never overwrite it.
- `cycle_cnt` is cleared on `start`, increments every RUN edge, and saturates.
- Termination is evaluated on the same edge as the checks, using that edge's results. Priority: fail-stop (`STOP_ON_FAIL`=1 and any fail this edge) > halt (`is_halted`) > timeout (`cycle_cnt == MAX_CYCLES-1`) > all checked (no pending entries remain after this edge).
- DONE: outputs frozen. `tbl_we` is ignored in RUN and in DONE.
- `reset` (any state, including mid-run): state IDLE, all entries unloaded, counters, `cycle_cnt`, `first_fail_*` and `done_cause` cleared to 0.

## Timing
- Reset values: `running`=0, `done`=0, `done_cause`=0, `pass_cnt`=0, `fail_cnt`=0, `first_fail_valid`=0, `first_fail_idx`=0, `first_fail_got`=0, `cycle_cnt`=0, `all_pass`=0, `stat`=0.
- Inputs are sampled at the rising edge. Results are visible immediately after that edge (latency 1 edge). There is no lookahead and no buffering.
- `start` edge → `running`=1 after that edge. The check of `num_inst` begins at the next edge.
- Terminating edge → `done`=1 and `running`=0 after that edge. Checks made on that edge are included in the counts.
- Timeout: with `MAX_CYCLES`=N, `done` rises after the N-th RUN edge.
- `stat` is purely combinational from `stat_idx` and the registered status.

## Test plan
- Load entries 0:(3,0x0000), 1:(5,0x0002); start; drive `num_inst` 3 then 5 with `output_port` 0 then 2 → `pass_cnt`=2, `done`, `done_cause`=0, `all_pass`=1.
- `STOP_ON_FAIL`=1; entry 0:(3,0x0001); `output_port`=0xFFFE at `num_inst`=3 → `done_cause`=3, `first_fail_idx`=0, `first_fail_got`=0xFFFE, `stat(0)`=3.
- `STOP_ON_FAIL`=0; two failing entries with counts 4 and 6, then a pass at count 8 → run continues, `fail_cnt`=2, `pass_cnt`=1, `first_fail_idx` = index of the count-4 entry.
- `MAX_CYCLES`=10, one entry at count 100, `num_inst` never reaches it → `done` after the 10th RUN edge, `done_cause`=2, `stat`=1.
- Entry match and `is_halted` on the same edge with a mismatch, `STOP_ON_FAIL`=0 → fail is recorded, `done_cause`=1. Then assert `reset` mid-run in a second run → every output returns to its reset value and `stat`=0.

Source files
------------

// File: rtl/cpu_checkpoint_monitor.sv
// Checkpoint scoreboard: compares CPU output_port against a loaded (num_inst, answer) table.
// Latency 1 edge; no backpressure, results and termination registered on the checking edge.
module cpu_checkpoint_monitor #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_TEST     = 56,
  parameter int IDX_W        = 6,
  parameter int CYCLE_W      = 16,
  parameter int MAX_CYCLES   = 10000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tbl_we,
  input  logic [IDX_W-1:0]     tbl_idx,
  input  logic [WORD_SIZE-1:0] tbl_num_inst,
  input  logic [WORD_SIZE-1:0] tbl_ans,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  input  logic [IDX_W-1:0]     stat_idx,
  output logic [1:0]           stat,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           done_cause,
  output logic [IDX_W:0]       pass_cnt,
  output logic [IDX_W:0]       fail_cnt,
  output logic                 first_fail_valid,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_got,
  output logic [CYCLE_W-1:0]   cycle_cnt,
  output logic                 all_pass
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] ST_UNL  = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] C_ALL  = 2'd0;
  localparam logic [1:0] C_HALT = 2'd1;
  localparam logic [1:0] C_TOUT = 2'd2;
  localparam logic [1:0] C_FAIL = 2'd3;

  localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(MAX_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] inst_q [NUM_TEST];
  logic [WORD_SIZE-1:0] inst_d [NUM_TEST];
  logic [WORD_SIZE-1:0] ans_q  [NUM_TEST];
  logic [WORD_SIZE-1:0] ans_d  [NUM_TEST];
  logic [1:0]           status_q [NUM_TEST];
  logic [1:0]           status_d [NUM_TEST];
  logic [IDX_W:0]       pass_cnt_q, pass_cnt_d;
  logic [IDX_W:0]       fail_cnt_q, fail_cnt_d;
  logic                 ff_vld_q, ff_vld_d;
  logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
  logic [WORD_SIZE-1:0] ff_got_q, ff_got_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [1:0]           cause_q, cause_d;

  logic [IDX_W:0]       pass_add, fail_add, loaded_cnt;
  logic                 hit_fail, pending_left;
  logic [IDX_W-1:0]     hit_idx;

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    ans_d      = ans_q;
    status_d   = status_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_vld_d   = ff_vld_q;
    ff_idx_d   = ff_idx_q;
    ff_got_d   = ff_got_q;
    cycle_d    = cycle_q;
    cause_d    = cause_q;
    pass_add     = '0;
    fail_add     = '0;
    hit_fail     = 1'b0;
    hit_idx      = '0;
    pending_left = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tbl_we && (int'(tbl_idx) < NUM_TEST)) begin
          inst_d[tbl_idx]   = tbl_num_inst;
          ans_d[tbl_idx]    = tbl_ans;
          status_d[tbl_idx] = ST_PEND;
        end
        if (start) begin
          for (int i = 0; i < NUM_TEST; i++) begin
            if (status_d[i] != ST_UNL) status_d[i] = ST_PEND;
          end
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          ff_vld_d   = 1'b0;
          ff_idx_d   = '0;
          ff_got_d   = '0;
          cycle_d    = '0;
          cause_d    = C_ALL;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // Every pending entry is evaluated in parallel; the lowest failing index wins first_fail.
        for (int i = 0; i < NUM_TEST; i++) begin
          if (status_q[i] == ST_PEND) begin
            if (inst_q[i] == num_inst) begin
              if (output_port == ans_q[i]) begin
                status_d[i] = ST_PASS;
                pass_add    = pass_add + 1'b1;
              end else begin
                status_d[i] = ST_FAIL;
                fail_add    = fail_add + 1'b1;
                if (!hit_fail) begin
                  hit_fail = 1'b1;
                  hit_idx  = IDX_W'(i);
                end
              end
            end else begin
              pending_left = 1'b1;
            end
          end
        end
        pass_cnt_d = pass_cnt_q + pass_add;
        fail_cnt_d = fail_cnt_q + fail_add;
        if (hit_fail && !ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_idx_d = hit_idx;
          ff_got_d = output_port;
        end
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;

        if ((STOP_ON_FAIL != 0) && hit_fail) begin
          cause_d = C_FAIL;
          state_d = S_DONE;
        end else if (is_halted) begin
          cause_d = C_HALT;
          state_d = S_DONE;
        end else if (cycle_q == CYC_LAST) begin
          cause_d = C_TOUT;
          state_d = S_DONE;
        end else if (!pending_left) begin
          cause_d = C_ALL;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_vld_q   <= 1'b0;
      ff_idx_q   <= '0;
      ff_got_q   <= '0;
      cycle_q    <= '0;
      cause_q    <= C_ALL;
      for (int i = 0; i < NUM_TEST; i++) status_q[i] <= ST_UNL;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vld_q   <= ff_vld_d;
      ff_idx_q   <= ff_idx_d;
      ff_got_q   <= ff_got_d;
      cycle_q    <= cycle_d;
      cause_q    <= cause_d;
      for (int i = 0; i < NUM_TEST; i++) status_q[i] <= status_d[i];
    end
  end

  // Table payload needs no reset: an entry is only meaningful once its status is loaded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      inst_q[i] <= inst_d[i];
      ans_q[i]  <= ans_d[i];
    end
  end

  always_comb begin
    stat       = ST_UNL;
    loaded_cnt = '0;
    if (int'(stat_idx) < NUM_TEST) stat = status_q[stat_idx];
    for (int i = 0; i < NUM_TEST; i++) begin
      if (status_q[i] != ST_UNL) loaded_cnt = loaded_cnt + 1'b1;
    end
  end

  assign running          = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign done_cause       = cause_q;
  assign pass_cnt         = pass_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_valid = ff_vld_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_got   = ff_got_q;
  assign cycle_cnt        = cycle_q;
  assign all_pass         = done && (fail_cnt_q == '0) && (pass_cnt_q == loaded_cnt);

endmodule
